// File: rtl/braille_pkg.sv
// Shared definitions for the Braille cell driver: dot patterns, scan states
// and the BCD range check.
package braille_pkg;

  localparam logic [5:0] PAT_0   = 6'b011010;
  localparam logic [5:0] PAT_1   = 6'b000001;
  localparam logic [5:0] PAT_2   = 6'b000011;
  localparam logic [5:0] PAT_3   = 6'b001001;
  localparam logic [5:0] PAT_4   = 6'b011001;
  localparam logic [5:0] PAT_5   = 6'b010001;
  localparam logic [5:0] PAT_6   = 6'b001011;
  localparam logic [5:0] PAT_7   = 6'b011011;
  localparam logic [5:0] PAT_8   = 6'b010011;
  localparam logic [5:0] PAT_9   = 6'b001010;
  localparam logic [5:0] PAT_NUM = 6'b111100;

  typedef enum logic [1:0] {LOAD, FIRE, GAP} state_e;

  function automatic logic bcd_is_valid(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/braille_cell_driver_if.sv
// Digit stream into the Braille cell driver (valid/ready with frame marker).
interface braille_cell_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_bcd;
  logic       in_last;

  modport master (output in_valid, in_bcd, in_last, input in_ready);
  modport slave  (input in_valid, in_bcd, in_last, output in_ready);
endinterface

// File: rtl/braille_digit_enc.sv
// Combinational BCD digit to 6-dot Braille pattern; non-BCD codes give a
// blank pattern and raise invalid.
module braille_digit_enc
  import braille_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [5:0] pat,
  output logic       invalid
);

  always_comb begin
    pat = 6'b000000;
    case (bcd)
      4'd0: pat = PAT_0;
      4'd1: pat = PAT_1;
      4'd2: pat = PAT_2;
      4'd3: pat = PAT_3;
      4'd4: pat = PAT_4;
      4'd5: pat = PAT_5;
      4'd6: pat = PAT_6;
      4'd7: pat = PAT_7;
      4'd8: pat = PAT_8;
      4'd9: pat = PAT_9;
      default: pat = 6'b000000;
    endcase
  end

  assign invalid = !bcd_is_valid(bcd);

endmodule

// File: rtl/braille_cell_driver.sv
// Collects a frame of BCD digits, then fires each actuator cell in turn for
// HOLD cycles with a one-cycle break-before-make gap between cells.
module braille_cell_driver
  import braille_pkg::*;
#(
  parameter int CELLS   = 4,
  parameter int HOLD    = 1000,
  parameter int NUM_IND = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  braille_cell_driver_if.slave src,
  output logic [CELLS-1:0]     cell_sel,
  output logic [5:0]           dots,
  output logic                 fire,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = $clog2(CELLS);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(CELLS - NUM_IND - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(CELLS - 1);

  state_e           state_reg, state_next;
  logic [CW-1:0]    slot_reg, cell_reg, wr_idx;
  logic [HW-1:0]    hold_reg;
  logic [5:0]       buf_reg [CELLS];
  logic             ready_reg, busy_reg, fire_reg, err_reg;
  logic [CELLS-1:0] cell_sel_reg, sel_onehot;
  logic [5:0]       dots_reg, cell_pat, enc_pat;
  logic             enc_inv, accept, frame_end;

  braille_digit_enc u_enc (
    .bcd     (src.in_bcd),
    .pat     (enc_pat),
    .invalid (enc_inv)
  );

  assign wr_idx = slot_reg + CW'(NUM_IND);

  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_sel
      assign sel_onehot[gi] = (cell_reg == CW'(gi));
    end
  endgenerate

  assign cell_pat = (NUM_IND != 0 && cell_reg == '0) ? PAT_NUM : buf_reg[cell_reg];

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    frame_end  = 1'b0;
    case (state_reg)
      LOAD: begin
        accept    = src.in_valid & ready_reg;
        frame_end = accept & (src.in_last | (slot_reg == SLOT_LAST));
        if (frame_end) state_next = FIRE;
      end
      FIRE: if (hold_reg == '0) state_next = GAP;
      GAP:  state_next = (cell_reg == CELL_LAST) ? LOAD : FIRE;
      default: state_next = LOAD;
    endcase
  end

  // Pin outputs trail the state by one cycle; ready/busy are framed so that
  // the trailing final gap still reads as busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= LOAD;
      slot_reg     <= '0;
      cell_reg     <= '0;
      hold_reg     <= '0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      fire_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cell_sel_reg <= '0;
      dots_reg     <= '0;
      for (int k = 0; k < CELLS; k++) buf_reg[k] <= '0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == LOAD) && (state_reg == LOAD);
      busy_reg  <= (state_next != LOAD) || (state_reg != LOAD);

      if (accept) begin
        slot_reg <= frame_end ? '0 : slot_reg + CW'(1);
        err_reg  <= (slot_reg == '0) ? enc_inv : (err_reg | enc_inv);
        // First digit of a frame wipes stale patterns from the previous frame.
        for (int k = 0; k < CELLS; k++) begin
          if (CW'(k) == wr_idx) buf_reg[k] <= enc_pat;
          else if (slot_reg == '0) buf_reg[k] <= '0;
        end
      end

      if (state_next == FIRE && state_reg != FIRE) hold_reg <= HW'(HOLD - 1);
      else if (state_reg == FIRE) hold_reg <= hold_reg - HW'(1);

      if (state_reg == GAP) cell_reg <= (cell_reg == CELL_LAST) ? '0 : cell_reg + CW'(1);

      fire_reg     <= (state_reg == FIRE);
      cell_sel_reg <= (state_reg == FIRE) ? sel_onehot : '0;
      dots_reg     <= (state_reg == FIRE) ? cell_pat : '0;
    end
  end

  assign src.in_ready = ready_reg;
  assign cell_sel     = cell_sel_reg;
  assign dots         = dots_reg;
  assign fire         = fire_reg;
  assign busy         = busy_reg;
  assign err          = err_reg;

endmodule

// File: doc/braille_cell_driver.md
# braille_cell_driver

Parametrised multi-cell Braille display driver. It accepts a frame of BCD digits over a valid/ready stream and encodes each digit to its 6-dot Braille pattern, with an optional leading number indicator. It then fires the actuator cells one at a time, each for a programmable hold time, with break-before-make gaps between cells. It sits between the digit source and the solenoid pin drivers of the display head.

## Interface
- CELLS, 4, number of physical cells (2..16)
- HOLD, 1000, cycles each cell is fired (>= 2)
- NUM_IND, 1, 1 = cell 0 always shows the number indicator and digits fill cells 1..CELLS-1; 0 = digits fill cells 0..CELLS-1
- CLK  input  1  single clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- IN_VALID  input  1  digit present
- IN_READY  output  1  block can accept a digit
- IN_BCD  input  4  BCD digit
- IN_LAST  input  1  qualifies the accepted digit as the last in the frame
- CELL_SEL  output  CELLS  one-hot cell enable
- DOTS  output  6  dot pattern; DOTS[0] = dot 1 … DOTS[5] = dot 6
- FIRE  output  1  actuator strobe
- BUSY  output  1  scan in progress
- ERR  output  1  sticky: the frame contained an invalid BCD code

## Operation
- Slots per frame: S = CELLS − NUM_IND. A digit is accepted when IN_VALID & IN_READY.
- Encoding (dot pattern, DOTS[5:0]):
  - 1 = 000001, 2 = 000011, 3 = 001001, 4 = 011001, 5 = 010001
  - 6 = 001011, 7 = 011011, 8 = 010011, 9 = 001010, 0 = 011010
  - Number indicator = 111100.
- Codes 10–15: the cell stores 000000 and ERR is set.
- The buffer stores encoded patterns, one 6-bit entry per cell.
- States:
  - LOAD: IN_READY = 1.
    - The first accept of a frame clears all buffer entries to 000000 and clears ERR; ERR is then set if that digit is invalid.
    - The frame ends on the S-th accept or on an accept with IN_LAST = 1, whichever comes first; the state then goes to FIRE.
    - Unfilled cells remain blank.
  - FIRE: drive CELL_SEL = one-hot(i), DOTS = buf[i], FIRE = 1 for exactly HOLD cycles.
  - GAP: CELL_SEL, DOTS and FIRE are all 0 for 1 cycle.
    - If i < CELLS−1, increment i and go to FIRE.
    - Otherwise clear i and go to LOAD.
- Blank cells are still fired, with DOTS = 000000, so that their pins retract.
- IN_LAST on a digit that is not accepted is ignored.
- BUSY = 1 in FIRE and GAP.
- IN_READY = 0 in FIRE and GAP. No input is buffered during a scan.

## Timing
- Reset:
  - CELL_SEL, DOTS, FIRE, BUSY, ERR and IN_READY are all 0; state = LOAD; i = 0; buffer cleared.
  - IN_READY rises on the first CLK edge after RST_N deasserts.
- All outputs are registered; there is no combinational path from input to output.
- The cycle after the frame-ending accept: IN_READY = 0, BUSY = 1. The next cycle: FIRE = 1 for cell 0.
- Scan length: CELLS × (HOLD + 1) cycles from the first FIRE to the return to LOAD.
- IN_READY = 1 again on the cycle after the final GAP.
- The HOLD counter is wide enough for HOLD; it reloads at each FIRE entry.
- Reset asserted mid-scan: all outputs drop to 0 asynchronously. The frame is discarded and not resumed.
- CELL_SEL is never multi-hot. CELL_SEL is never non-zero while FIRE = 0.

## Structure
- Package braille_pkg:
  - localparams for the ten digit patterns and the number indicator (111100);
  - state enum {LOAD, FIRE, GAP};
  - a function for the BCD-valid check.
- Sub-module braille_digit_enc: combinational 4-bit BCD in, 6-bit pattern plus invalid flag out. It is instantiated once at the accept path.
- The top level holds the buffer, slot and cell counters, the HOLD counter and the FSM.

## Test plan
- Default frame (CELLS=4, HOLD=4, NUM_IND=1): send 3, 7, 0 (last auto at S=3) → cells 0..3 fire with DOTS 111100, 001001, 011011, 011010; each FIRE is 4 cycles, each gap 1 cycle; total 20 cycles; IN_READY returns on cycle 21.
- Early end: send 5 with IN_LAST=1 → cells fire 111100, 010001, 000000, 000000; ERR = 0.
- Invalid code: send 2, 12, 9 → cell 2 = 000000, ERR = 1. The next frame 1, 1, 1 → ERR clears on its first accept.
- Handshake: hold IN_VALID high during a scan → no accepts and IN_READY = 0 throughout. Also insert 3-cycle IN_VALID gaps in LOAD → the frame is assembled correctly.
- Reset mid-scan: assert RST_N low while cell 2 is firing → outputs are 0 immediately. After release, send 4, 8, 6 → a fresh scan shows 111100, 011001, 010011, 001011.
- NUM_IND=0, CELLS=2: send 0, 9 → cell 0 = 011010, cell 1 = 001010; check CELL_SEL stays one-hot or zero.
